// File: rtl/game_pkg.sv
// Shared definitions for the game round controller: state encoding and the
// constants of the prompt-selection LFSR.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHOW     = 3'd1,
        ST_CORRECT  = 3'd2,
        ST_WRONG    = 3'd3,
        ST_GAMEOVER = 3'd4
    } game_state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One Galois step: shift right, fold the taps back in when a 1 drops out.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur, input logic [15:0] taps);
        lfsr_step = cur[0] ? ((cur >> 1) ^ taps) : (cur >> 1);
    endfunction

endpackage

// File: rtl/prompt_lfsr.sv
// 16-bit Galois LFSR used to pick prompts; reloads its seed on reset.
module prompt_lfsr
    import game_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED,
    parameter logic [15:0] TAPS = LFSR_TAPS
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [15:0] value
);

    // Free-running pseudo-random sequence, advanced whenever enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= SEED;
        end else if (en) begin
            value <= lfsr_step(value, TAPS);
        end
    end

endmodule

// File: rtl/game_round_fsm.sv
// Reaction-game round controller. Shows a prompt, judges one key press
// against the prompt's target code (or its negation for "NOT" prompts),
// handles timeouts, lives and score, and times the result display.
//
// Handshake: key_valid is a one-cycle strobe qualifying key_code; it is only
// looked at in SHOW, there is no back-pressure. start is a level sampled only
// in IDLE/GAMEOVER. Result pulses are one cycle wide and coincide with entry
// into CORRECT or WRONG.
module game_round_fsm
    import game_pkg::*;
#(
    parameter int NUM_PROMPTS  = 6,
    parameter int KEY_W        = 16,
    parameter int TIMEOUT_CYC  = 150000000,
    parameter int FEEDBACK_CYC = 50000000,
    parameter int LIVES        = 3,
    parameter int SCORE_W      = 8,
    parameter int INV_EN       = 1
)(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           key_valid,
    input  logic [KEY_W-1:0]               key_code,
    input  logic [NUM_PROMPTS*KEY_W-1:0]   expect_codes,
    output logic [$clog2(NUM_PROMPTS)-1:0] prompt_id,
    output logic                           prompt_inv,
    output logic                           prompt_valid,
    output logic                           res_correct,
    output logic                           res_wrong,
    output logic                           res_timeout,
    output logic [3:0]                     lives_left,
    output logic [SCORE_W-1:0]             score,
    output logic                           game_over,
    output logic [2:0]                     state
);

    localparam int PID_W   = $clog2(NUM_PROMPTS);
    localparam int TMR_MAX = (TIMEOUT_CYC > FEEDBACK_CYC) ? TIMEOUT_CYC : FEEDBACK_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0]   SHOW_LAST  = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0]   FB_LAST    = TMR_W'(FEEDBACK_CYC - 1);
    localparam logic [3:0]         LIVES_INIT = 4'(LIVES);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    game_state_e        state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [SCORE_W-1:0] score_d;
    logic [3:0]         lives_d;
    logic [PID_W-1:0]   pid_d;
    logic               inv_d;
    logic               correct_d, wrong_d, timeout_d;
    logic               latch_prompt;

    logic [15:0]        lfsr_val;
    logic [7:0]         lfsr_mod;
    logic [KEY_W-1:0]   target;
    logic               key_match;
    logic               key_hit;
    logic               unused_lfsr_bits;

    prompt_lfsr #(
        .SEED (LFSR_SEED),
        .TAPS (LFSR_TAPS)
    ) u_prompt_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .value (lfsr_val)
    );

    // Prompt selection only uses the low byte and the top bit.
    assign unused_lfsr_bits = ^lfsr_val[14:8];
    assign lfsr_mod         = lfsr_val[7:0] % 8'(NUM_PROMPTS);

    // Key judgement against the target of the prompt currently on display.
    assign target    = expect_codes[int'(prompt_id) * KEY_W +: KEY_W];
    assign key_match = (key_code == target);
    assign key_hit   = prompt_inv ? !key_match : key_match;

    assign state = state_q;

    // Next-state, timer, score/lives and result-pulse decisions.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        score_d      = score;
        lives_d      = lives_left;
        pid_d        = prompt_id;
        inv_d        = prompt_inv;
        correct_d    = 1'b0;
        wrong_d      = 1'b0;
        timeout_d    = 1'b0;
        latch_prompt = 1'b0;

        case (state_q)
            ST_IDLE, ST_GAMEOVER: begin
                if (start) begin
                    state_d      = ST_SHOW;
                    lives_d      = LIVES_INIT;
                    score_d      = '0;
                    latch_prompt = 1'b1;
                end
            end
            ST_SHOW: begin
                // A key arriving on the last allowed cycle beats the timeout.
                if (key_valid) begin
                    if (key_hit) begin
                        state_d   = ST_CORRECT;
                        correct_d = 1'b1;
                        score_d   = (score == SCORE_MAX) ? score : score + SCORE_W'(1);
                    end else begin
                        state_d = ST_WRONG;
                        wrong_d = 1'b1;
                        lives_d = (lives_left == 4'd0) ? 4'd0 : lives_left - 4'd1;
                    end
                end else if (timer_q == SHOW_LAST) begin
                    state_d   = ST_WRONG;
                    timeout_d = 1'b1;
                    lives_d   = (lives_left == 4'd0) ? 4'd0 : lives_left - 4'd1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_CORRECT: begin
                if (timer_q == FB_LAST) begin
                    state_d      = ST_SHOW;
                    latch_prompt = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_WRONG: begin
                if (timer_q == FB_LAST) begin
                    if (lives_left == 4'd0) begin
                        state_d = ST_GAMEOVER;
                    end else begin
                        state_d      = ST_SHOW;
                        latch_prompt = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // One timer serves every state, so it restarts on each transition.
        if (state_d != state_q) begin
            timer_d = '0;
        end

        if (latch_prompt) begin
            pid_d = lfsr_mod[PID_W-1:0];
            inv_d = (INV_EN != 0) && lfsr_val[15];
        end
    end

    // State register plus every registered output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            score        <= '0;
            lives_left   <= LIVES_INIT;
            prompt_id    <= '0;
            prompt_inv   <= 1'b0;
            prompt_valid <= 1'b0;
            game_over    <= 1'b0;
            res_correct  <= 1'b0;
            res_wrong    <= 1'b0;
            res_timeout  <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            score        <= score_d;
            lives_left   <= lives_d;
            prompt_id    <= pid_d;
            prompt_inv   <= inv_d;
            prompt_valid <= (state_d == ST_SHOW);
            game_over    <= (state_d == ST_GAMEOVER);
            res_correct  <= correct_d;
            res_wrong    <= wrong_d;
            res_timeout  <= timeout_d;
        end
    end

endmodule

// File: tb/tb_game_round_fsm.sv
// Bench for game_round_fsm with short timings. Inputs are driven and outputs
// sampled on the falling clock edge. A reference model tracks the LFSR value
// cycle by cycle and derives prompts, lives and score from the game rules.
module tb_game_round_fsm;

    localparam int NP = 6;
    localparam int KW = 16;
    localparam int TO = 8;
    localparam int FB = 4;
    localparam int LV = 2;
    localparam int SW = 8;

    localparam int S_IDLE = 0, S_SHOW = 1, S_CORRECT = 2, S_WRONG = 3, S_OVER = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              key_valid;
    logic [KW-1:0]     key_code;
    logic [NP*KW-1:0]  expect_codes;
    logic [2:0]        prompt_id;
    logic              prompt_inv;
    logic              prompt_valid;
    logic              res_correct;
    logic              res_wrong;
    logic              res_timeout;
    logic [3:0]        lives_left;
    logic [SW-1:0]     score;
    logic              game_over;
    logic [2:0]        state;

    int total = 0;
    int bad   = 0;

    // Reference model
    logic [15:0]   m_lfsr;
    int            m_lives;
    int            m_score;
    int            m_pid;
    logic          m_inv;
    logic          m_over;
    logic [KW-1:0] codes [NP];
    logic [3:0]    exp_q[$];   // predicted {inv, prompt_id} for each upcoming SHOW entry

    game_round_fsm #(
        .NUM_PROMPTS  (NP),
        .KEY_W        (KW),
        .TIMEOUT_CYC  (TO),
        .FEEDBACK_CYC (FB),
        .LIVES        (LV),
        .SCORE_W      (SW),
        .INV_EN       (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .expect_codes (expect_codes),
        .prompt_id    (prompt_id),
        .prompt_inv   (prompt_inv),
        .prompt_valid (prompt_valid),
        .res_correct  (res_correct),
        .res_wrong    (res_wrong),
        .res_timeout  (res_timeout),
        .lives_left   (lives_left),
        .score        (score),
        .game_over    (game_over),
        .state        (state)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [15:0] next_lfsr(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_pulses(input string tag, input int c, input int w, input int t);
        check({tag, "_correct"}, 32'(res_correct), 32'(c));
        check({tag, "_wrong"},   32'(res_wrong),   32'(w));
        check({tag, "_timeout"}, 32'(res_timeout), 32'(t));
    endtask

    // One clock cycle; the model LFSR steps with the DUT while out of reset.
    task automatic tick();
        @(posedge clk);
        m_lfsr = next_lfsr(m_lfsr);
        @(negedge clk);
    endtask

    // The prompt latched at the next edge comes from the current LFSR value.
    task automatic predict_latch();
        int pid;
        pid = int'(m_lfsr[7:0]) % NP;
        exp_q.push_back({m_lfsr[15], 3'(pid)});
    endtask

    task automatic check_show_entry(input string tag);
        logic [3:0] e;
        check({tag, "_state"}, 32'(state), S_SHOW);
        check({tag, "_valid"}, 32'(prompt_valid), 1);
        check({tag, "_over"},  32'(game_over), 0);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_queue: observed=empty expected=prediction", tag);
        end else begin
            e     = exp_q.pop_front();
            m_pid = int'(e[2:0]);
            m_inv = e[3];
            check({tag, "_pid"}, 32'(prompt_id), 32'(m_pid));
            check({tag, "_inv"}, 32'(prompt_inv), 32'(m_inv));
        end
    endtask

    task automatic do_start();
        predict_latch();
        start = 1'b1;
        tick();
        start   = 1'b0;
        m_lives = LV;
        m_score = 0;
        m_over  = 1'b0;
        check_show_entry("start");
        check("start_lives", 32'(lives_left), 32'(m_lives));
        check("start_score", 32'(score), 32'(m_score));
        check_pulses("start", 0, 0, 0);
    endtask

    // kind: 0 = right key, 1 = wrong key, 2 = let it time out.
    task automatic show_round(input int delay, input int kind);
        logic [KW-1:0] tgt;
        int            fb_state;
        tgt = codes[m_pid];
        if (kind == 2) begin
            repeat (TO - 1) tick();
            check("to_last_cycle_state", 32'(state), S_SHOW);
            check_pulses("to_early", 0, 0, 0);
            tick();
            check_pulses("to", 0, 0, 1);
            check("to_state", 32'(state), S_WRONG);
            m_lives  = (m_lives > 0) ? m_lives - 1 : 0;
            fb_state = S_WRONG;
        end else begin
            repeat (delay) tick();
            key_valid = 1'b1;
            if (kind == 0)
                key_code = m_inv ? (tgt ^ 16'd1) : tgt;
            else
                key_code = m_inv ? tgt : (tgt ^ 16'($urandom_range(1, 65535)));
            tick();
            key_valid = 1'b0;
            if (kind == 0) begin
                check_pulses("key_right", 1, 0, 0);
                check("key_right_state", 32'(state), S_CORRECT);
                m_score  = (m_score < 255) ? m_score + 1 : 255;
                fb_state = S_CORRECT;
            end else begin
                check_pulses("key_wrong", 0, 1, 0);
                check("key_wrong_state", 32'(state), S_WRONG);
                m_lives  = (m_lives > 0) ? m_lives - 1 : 0;
                fb_state = S_WRONG;
            end
        end
        check("result_lives", 32'(lives_left), 32'(m_lives));
        check("result_score", 32'(score), 32'(m_score));
        // Feedback display: keys and start must be ignored here.
        for (int i = 0; i < FB - 1; i++) begin
            key_valid = 1'($urandom_range(0, 1));
            key_code  = 16'($urandom);
            start     = 1'($urandom_range(0, 1));
            tick();
            key_valid = 1'b0;
            start     = 1'b0;
            check("fb_state", 32'(state), 32'(fb_state));
            check_pulses("fb", 0, 0, 0);
        end
        if (fb_state == S_WRONG && m_lives == 0) begin
            tick();
            check("over_state", 32'(state), S_OVER);
            check("over_flag", 32'(game_over), 1);
            check("over_valid", 32'(prompt_valid), 0);
            check_pulses("over", 0, 0, 0);
            m_over = 1'b1;
        end else begin
            predict_latch();
            tick();
            check_show_entry("next");
        end
        check("end_lives", 32'(lives_left), 32'(m_lives));
        check("end_score", 32'(score), 32'(m_score));
    endtask

    task automatic gameover_hold();
        for (int i = 0; i < 3; i++) begin
            key_valid = 1'($urandom_range(0, 1));
            key_code  = 16'($urandom);
            tick();
            key_valid = 1'b0;
            check("hold_state", 32'(state), S_OVER);
            check("hold_flag", 32'(game_over), 1);
            check("hold_lives", 32'(lives_left), 0);
            check("hold_score", 32'(score), 32'(m_score));
            check_pulses("hold", 0, 0, 0);
        end
    endtask

    task automatic random_round();
        int r;
        r = int'($urandom_range(0, 9));
        show_round(int'($urandom_range(0, TO - 1)), (r < 2) ? 1 : ((r < 3) ? 2 : 0));
        if (m_over) begin
            gameover_hold();
            do_start();
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(state), S_IDLE);
        check({tag, "_lives"}, 32'(lives_left), LV);
        check({tag, "_score"}, 32'(score), 0);
        check({tag, "_pid"},   32'(prompt_id), 0);
        check({tag, "_inv"},   32'(prompt_inv), 0);
        check({tag, "_valid"}, 32'(prompt_valid), 0);
        check({tag, "_over"},  32'(game_over), 0);
        check_pulses(tag, 0, 0, 0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        key_valid = 1'b0;
        key_code  = '0;
        m_lfsr    = 16'hACE1;
        m_over    = 1'b0;
        m_lives   = LV;
        m_score   = 0;
        m_pid     = 0;
        m_inv     = 1'b0;
        for (int i = 0; i < NP; i++) begin
            codes[i] = 16'($urandom);
            expect_codes[i*KW +: KW] = codes[i];
        end

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        reset  = 1'b0;
        m_lfsr = 16'hACE1;

        // IDLE ignores keys
        for (int i = 0; i < int'($urandom_range(1, 20)); i++) begin
            key_valid = 1'($urandom_range(0, 1));
            key_code  = 16'($urandom);
            tick();
            key_valid = 1'b0;
            check("idle_state", 32'(state), S_IDLE);
            check_pulses("idle", 0, 0, 0);
        end

        // Directed game: correct at timer 3, correct at last cycle,
        // timeout, then a wrong key at the last cycle ends the game.
        do_start();
        show_round(3, 0);
        show_round(TO - 1, 0);
        show_round(0, 2);
        show_round(TO - 1, 1);
        check("directed_game_over", 32'(game_over), 1);
        gameover_hold();

        // Restart from GAMEOVER, then inverted prompts: right key loses,
        // flipped key wins.
        do_start();
        for (int n = 0; n < 60 && !m_inv; n++) show_round(int'($urandom_range(0, TO - 1)), 0);
        show_round(int'($urandom_range(0, TO - 1)), 1);
        for (int n = 0; n < 60 && !m_inv; n++) show_round(int'($urandom_range(0, TO - 1)), 0);
        show_round(int'($urandom_range(0, TO - 1)), 0);

        // Randomized play
        for (int n = 0; n < 40; n++) random_round();

        // Score saturation
        if (!m_over) begin
            show_round(0, 1);
            while (!m_over) show_round(0, 2);
            gameover_hold();
        end
        do_start();
        for (int n = 0; n < 258; n++) show_round(int'($urandom_range(0, TO - 1)), 0);
        check("score_saturated", 32'(score), 255);

        // Reset in the middle of SHOW while a key is pending
        repeat (3) tick();
        key_valid = 1'b1;
        key_code  = codes[m_pid];
        #2 reset = 1'b1;
        #1 check_reset_values("async_rst");
        key_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_values("held_rst");
        reset  = 1'b0;
        m_lfsr = 16'hACE1;
        exp_q.delete();
        repeat (int'($urandom_range(0, 10))) tick();
        check("post_rst_idle", 32'(state), S_IDLE);
        do_start();
        for (int n = 0; n < 8; n++) random_round();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
